// File: rtl/lut_table_loader_if.sv
// Byte stream port for lut_table_loader: valid/ready handshake carrying one table byte per transfer.
interface lut_table_loader_if;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic       byte_ready;

  modport master (output byte_in, output byte_valid, input byte_ready);
  modport slave  (input byte_in, input byte_valid, output byte_ready);
endinterface

// File: rtl/lut_table_loader.sv
// Serialises table bytes MSB-first onto a serial_load_lut d/cs_n pair.
// Optional trailing checksum byte when LUT_LOADER_CHECKSUM_EN is defined.
module lut_table_loader #(
  parameter int unsigned TABLE_BITS = 256
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  lut_table_loader_if.slave   bus,
  output logic                sd_out,
  output logic                cs_n_out,
  output logic                busy,
  output logic                done,
  output logic                chk_err
);

  localparam int unsigned NBYTES = TABLE_BITS / 8;
  localparam int unsigned CNT_W  = $clog2(NBYTES + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NBYTES);

  typedef enum logic [1:0] {
    IDLE,
    LOAD
`ifdef LUT_LOADER_CHECKSUM_EN
    , CHK
`endif
  } state_t;

  state_t           state;
  logic [6:0]       shreg;
  logic [3:0]       bits_left;
  logic [CNT_W-1:0] byte_cnt;
  logic             ready;
  logic             accept;

  // Ready while the final bit of the current byte is on sd_out, so bytes abut with no cs_n gap.
  always_comb begin
    ready = 1'b0;
    case (state)
      LOAD:    ready = (byte_cnt != LAST_CNT) && (bits_left <= 4'd1);
`ifdef LUT_LOADER_CHECKSUM_EN
      CHK:     ready = 1'b1;
`endif
      default: ready = 1'b0;
    endcase
  end

  assign bus.byte_ready = ready;
  assign accept         = ready & bus.byte_valid;
  assign busy           = (state != IDLE);

`ifdef LUT_LOADER_CHECKSUM_EN
  logic [7:0] xor_acc;
  logic       chk_err_q;
  assign chk_err = chk_err_q;
`else
  assign chk_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      sd_out    <= 1'b0;
      cs_n_out  <= 1'b1;
      done      <= 1'b0;
      shreg     <= '0;
      bits_left <= '0;
      byte_cnt  <= '0;
`ifdef LUT_LOADER_CHECKSUM_EN
      xor_acc   <= '0;
      chk_err_q <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (abort) begin
        state     <= IDLE;
        cs_n_out  <= 1'b1;
        bits_left <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              state     <= LOAD;
              byte_cnt  <= '0;
              bits_left <= '0;
`ifdef LUT_LOADER_CHECKSUM_EN
              xor_acc   <= '0;
              chk_err_q <= 1'b0;
`endif
            end
          end
          LOAD: begin
            if (accept) begin
              sd_out    <= bus.byte_in[7];
              shreg     <= bus.byte_in[6:0];
              cs_n_out  <= 1'b0;
              bits_left <= 4'd8;
              byte_cnt  <= byte_cnt + 1'b1;
`ifdef LUT_LOADER_CHECKSUM_EN
              xor_acc   <= xor_acc ^ bus.byte_in;
`endif
            end else if (bits_left > 4'd1) begin
              sd_out    <= shreg[6];
              shreg     <= {shreg[5:0], 1'b0};
              bits_left <= bits_left - 4'd1;
            end else if (bits_left == 4'd1) begin
              // Last bit shifts into the LUT on this edge; hold it unless another byte follows.
              cs_n_out  <= 1'b1;
              bits_left <= '0;
              if (byte_cnt == LAST_CNT) begin
`ifdef LUT_LOADER_CHECKSUM_EN
                state <= CHK;
`else
                state <= IDLE;
                done  <= 1'b1;
`endif
              end
            end
          end
`ifdef LUT_LOADER_CHECKSUM_EN
          CHK: begin
            if (accept) begin
              chk_err_q <= (bus.byte_in != xor_acc);
              done      <= 1'b1;
              state     <= IDLE;
            end
          end
`endif
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lut_table_loader.sv
// Directed bench for lut_table_loader with a behavioural 256-bit serial LUT on d/cs_n.
module tb_lut_table_loader;

  localparam int TB_BITS = 256;

  logic clk = 1'b0;
  logic rst_n, start, abort;
  logic sd_out, cs_n_out, busy, done, chk_err;

  lut_table_loader_if bif ();

  lut_table_loader #(.TABLE_BITS(TB_BITS)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .bus      (bif.slave),
    .sd_out   (sd_out),
    .cs_n_out (cs_n_out),
    .busy     (busy),
    .done     (done),
    .chk_err  (chk_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [TB_BITS-1:0] lut;
  int          en_cnt, gap_cnt, done_cnt;
  logic [15:0] seq;

  // Downstream LUT: shifts d in on every edge where cs_n is low.
  always @(posedge clk) begin
    if (!cs_n_out) begin
      lut <= {lut[TB_BITS-2:0], sd_out};
      if (en_cnt < 16) seq = {seq[14:0], sd_out};
      en_cnt = en_cnt + 1;
    end else if (en_cnt > 0 && en_cnt < TB_BITS) begin
      gap_cnt = gap_cnt + 1;
    end
    if (done) done_cnt = done_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [TB_BITS-1:0] got, input logic [TB_BITS-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clr_mon();
    en_cnt = 0; gap_cnt = 0; done_cnt = 0; seq = '0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t;
    bif.byte_in = b;
    bif.byte_valid = 1'b1;
    t = 0;
    while (!bif.byte_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) check_eq("ready_timeout", 0, 1);
    @(negedge clk);
    bif.byte_valid = 1'b0;
  endtask

  function automatic logic [7:0] xor_of(input logic [TB_BITS-1:0] d);
    logic [7:0] x;
    x = '0;
    for (int i = 0; i < TB_BITS / 8; i++) x = x ^ d[TB_BITS-1-8*i -: 8];
    return x;
  endfunction

  // Full load; optional stall after byte stall_idx, start held high around byte start_idx.
  task automatic load_table(input logic [TB_BITS-1:0] data, input int stall_idx,
                            input int start_idx, input logic [7:0] ck);
    int t;
    clr_mon();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < TB_BITS / 8; i++) begin
      if (i == start_idx) start = 1'b1;
      send_byte(data[TB_BITS-1-8*i -: 8]);
      start = 1'b0;
      if (i == start_idx) check_eq("busy_after_start", busy, 1);
      if (i == stall_idx) begin
        t = 0;
        while (!bif.byte_ready && t < 50) begin
          @(negedge clk);
          t++;
        end
        repeat (5) @(negedge clk);
      end
    end
`ifdef LUT_LOADER_CHECKSUM_EN
    send_byte(ck);
`else
    if (ck != 8'h00) check_eq("no_cksum_byte", 0, 0);
`endif
    t = 0;
    while (done_cnt == 0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (t >= 500) check_eq("done_timeout", 0, 1);
    repeat (3) @(negedge clk);
  endtask

  logic [TB_BITS-1:0] ramp, a5s, d6;

  initial begin
    for (int i = 0; i < 32; i++) ramp[TB_BITS-1-8*i -: 8] = 8'(i);
    for (int i = 0; i < 32; i++) a5s[TB_BITS-1-8*i -: 8] = 8'hA5;
    d6 = '0;
    d6[255:240] = 16'h8001;
    lut = '0;
    clr_mon();
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    bif.byte_in = '0; bif.byte_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_sd", sd_out, 0);
    check_eq("rst_cs_n", cs_n_out, 1);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_chk_err", chk_err, 0);
    check_eq("rst_ready", bif.byte_ready, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: back-to-back ramp
    load_table(ramp, -1, -1, xor_of(ramp));
    check_eq("t1_en_edges", en_cnt, 256);
    check_eq("t1_gap", gap_cnt, 0);
    check_eq("t1_done", done_cnt, 1);
    check_eq("t1_top", lut[255:248], 8'h00);
    check_eq("t1_bot", lut[7:0], 8'h1F);
    check_eq("t1_table", lut, ramp);
    check_eq("t1_busy", busy, 0);
    check_eq("t1_chk_err", chk_err, 0);

    // 2: underrun stall after byte 3
    lut = '0;
    load_table(ramp, 3, -1, xor_of(ramp));
    check_eq("t2_en_edges", en_cnt, 256);
    check_eq("t2_gap", gap_cnt, 5);
    check_eq("t2_done", done_cnt, 1);
    check_eq("t2_table", lut, ramp);

    // 3: abort after byte 10
    clr_mon();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i <= 10; i++) send_byte(8'(i));
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_eq("t3_busy", busy, 0);
    check_eq("t3_cs_n", cs_n_out, 1);
    check_eq("t3_ready", bif.byte_ready, 0);
    repeat (10) @(negedge clk);
    check_eq("t3_no_done", done_cnt, 0);
    load_table(ramp, -1, -1, xor_of(ramp));
    check_eq("t3_reload_done", done_cnt, 1);
    check_eq("t3_reload_table", lut, ramp);

    // 4: start while busy is ignored, then reset mid-load
    load_table(ramp, -1, 5, xor_of(ramp));
    check_eq("t4_done", done_cnt, 1);
    check_eq("t4_table", lut, ramp);
    clr_mon();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 5; i++) send_byte(8'hFF);
    repeat (2) @(negedge clk);
    check_eq("t4_mid_cs_n", cs_n_out, 0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_eq("t4_rst_sd", sd_out, 0);
    check_eq("t4_rst_cs_n", cs_n_out, 1);
    check_eq("t4_rst_ready", bif.byte_ready, 0);
    check_eq("t4_rst_busy", busy, 0);
    repeat (5) @(negedge clk);
    check_eq("t4_no_done", done_cnt, 0);

`ifdef LUT_LOADER_CHECKSUM_EN
    // 5: checksum good then bad
    load_table(a5s, -1, -1, 8'h00);
    check_eq("t5_good_err", chk_err, 0);
    check_eq("t5_good_done", done_cnt, 1);
    load_table(a5s, -1, -1, 8'h01);
    check_eq("t5_bad_err", chk_err, 1);
    repeat (10) @(negedge clk);
    check_eq("t5_bad_held", chk_err, 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq("t5_cleared", chk_err, 0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
`else
    load_table(a5s, -1, -1, 8'h00);
    check_eq("t5_tied_err", chk_err, 0);
    check_eq("t5_table", lut, a5s);
`endif

    // 6: bit order across two bytes
    load_table(d6, -1, -1, xor_of(d6));
    check_eq("t6_seq", seq, 16'h8001);
    check_eq("t6_table", lut, d6);
    check_eq("t6_done", done_cnt, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
